riscv_irq_source_unit: RTL

Interrupt source for the core's level-triggered irq/id/secure request and ack interface. Collects 32 event pulses into a pending register, applies a software mask, selects the highest-numbered unmasked pending line, and presents it to the core. It sits between the peripheral and event fabric and the core.
- On the core's ack, clears the acknowledged line.
- Software access to mask, secure and pending state is through a small register port.

---
 rtl/riscv_irq_source_unit_if.sv | 25 ++
 rtl/riscv_irq_source_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/riscv_irq_source_unit_if.sv
// Request/ack and register-port bundle between the interrupt source unit and its neighbours.
// The slave modport is the interrupt source unit; the master side is the core/fabric/bus.
interface riscv_irq_source_unit_if;
  logic [31:0] event_i;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_sec_o;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;

  modport slave (
    input  event_i, reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i, irq_ack_i, irq_ack_id_i,
    output reg_rdata_o, irq_o, irq_id_o, irq_sec_o
  );

  modport master (
    output event_i, reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i, irq_ack_i, irq_ack_id_i,
    input  reg_rdata_o, irq_o, irq_id_o, irq_sec_o
  );
endinterface

// File: rtl/riscv_irq_source_unit.sv
// Level-triggered interrupt source: 32 pending lines, software mask/secure attributes,
// highest-index priority select and an IDLE/REQ/HOLDOFF handshake with the core.
module riscv_irq_source_unit #(
  parameter int                   NUM_IRQ  = 32,
  parameter logic [NUM_IRQ-1:0]   MASK_RST = 32'h0000_0000,
  parameter logic [NUM_IRQ-1:0]   SEC_RST  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_irq_source_unit_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [1:0] A_MASK     = 2'd0;
  localparam logic [1:0] A_SECURE   = 2'd1;
  localparam logic [1:0] A_PENDING  = 2'd2;
  localparam logic [1:0] A_PEND_SET = 2'd3;

  logic [NUM_IRQ-1:0] pend_r;
  logic [NUM_IRQ-1:0] mask_r;
  logic [NUM_IRQ-1:0] sec_r;
  logic [1:0]         state_r;
  logic               irq_r;
  logic [4:0]         id_r;
  logic               sec_out_r;

  logic               wr_s;
  logic [NUM_IRQ-1:0] set_s;
  logic [NUM_IRQ-1:0] clr_s;
  logic [NUM_IRQ-1:0] pend_nxt_s;
  logic [NUM_IRQ-1:0] active_s;
  logic               any_s;
  logic [4:0]         winner_s;
  logic               sec_sel_s;
  logic [31:0]        rdata_s;

  assign wr_s = bus.reg_req_i & bus.reg_we_i;

  // Pending next-state: set sources are OR-ed in last so a same-cycle set beats any clear.
  always_comb begin
    set_s = bus.event_i;
    clr_s = {NUM_IRQ{1'b0}};
    if (wr_s && (bus.reg_addr_i == A_PEND_SET)) begin
      set_s = bus.event_i | bus.reg_wdata_i;
    end else begin
      set_s = bus.event_i;
    end
    if (wr_s && (bus.reg_addr_i == A_PENDING)) begin
      clr_s = bus.reg_wdata_i;
    end else begin
      clr_s = {NUM_IRQ{1'b0}};
    end
    if (bus.irq_ack_i) begin
      clr_s = clr_s | (32'h0000_0001 << bus.irq_ack_id_i);
    end else begin
      clr_s = clr_s;
    end
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
  end

  // Priority select: the scan runs upward so the highest set index is the last one kept.
  always_comb begin
    active_s = pend_r & mask_r;
    any_s    = |active_s;
    winner_s = 5'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (active_s[i]) begin
        winner_s = 5'(i);
      end else begin
        winner_s = winner_s;
      end
    end
    sec_sel_s = sec_r[winner_s];
  end

  // Register read mux; reads of PENDING_SET and all write cycles return zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.reg_req_i && !bus.reg_we_i) begin
      case (bus.reg_addr_i)
        A_MASK:    rdata_s = mask_r;
        A_SECURE:  rdata_s = sec_r;
        A_PENDING: rdata_s = pend_r;
        default:   rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Software-visible state: mask, secure and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_IRQ{1'b0}};
      mask_r <= MASK_RST;
      sec_r  <= SEC_RST;
    end else begin
      pend_r <= pend_nxt_s;
      if (wr_s && (bus.reg_addr_i == A_MASK)) begin
        mask_r <= bus.reg_wdata_i;
      end
      if (wr_s && (bus.reg_addr_i == A_SECURE)) begin
        sec_r <= bus.reg_wdata_i;
      end
    end
  end

  // Request handshake; HOLDOFF forces one low cycle after every ack so the core cannot re-take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      irq_r     <= 1'b0;
      id_r      <= 5'd0;
      sec_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_r   <= ST_REQ;
            irq_r     <= 1'b1;
            id_r      <= winner_s;
            sec_out_r <= sec_sel_s;
          end
        end
        ST_REQ: begin
          if (bus.irq_ack_i) begin
            state_r   <= ST_HOLDOFF;
            irq_r     <= 1'b0;
            sec_out_r <= 1'b0;
          end else if (!any_s) begin
            state_r   <= ST_IDLE;
            irq_r     <= 1'b0;
          end else begin
            id_r      <= winner_s;
            sec_out_r <= sec_sel_s;
          end
        end
        ST_HOLDOFF: begin
          state_r <= ST_IDLE;
          irq_r   <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          irq_r     <= 1'b0;
          sec_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_rdata_o = rdata_s;
  assign bus.irq_o       = irq_r;
  assign bus.irq_id_o    = id_r;
  assign bus.irq_sec_o   = sec_out_r;

endmodule
